// File: rtl/store_narrow_unit.sv
`timescale 1ns/1ps
// Store-side narrowing unit: byte/half stores via read-modify-write of the
// cache word, word stores written directly, misaligned/illegal sizes rejected.
module store_narrow_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_e;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_BAD = 2'b11} size_e;

  state_e            state_q, state_d;
  size_e             size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       data_q, data_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              reject;

  // Little-endian lane merge of the captured store data into the cache word.
  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [15:0] d,
                                             input size_e sz, input logic [1:0] lane);
    logic [31:0] m;
    m = old;
    if (sz == SZ_BYTE) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (lane == 2'(k)) m[8*k +: 8] = d[7:0];
      end
    end else if (lane[1]) begin
      m[31:16] = d;
    end else begin
      m[15:0] = d;
    end
    return m;
  endfunction

  assign reject = (req_size == SZ_BAD) ||
                  ((req_size == SZ_HALF) && req_addr[0]) ||
                  ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  assign req_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    lane_d      = lane_q;
    data_d      = data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d     = size_e'(req_size);
          lane_d     = req_addr[1:0];
          data_d     = req_data[15:0];
          mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
          if (reject) begin
            state_d = ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (req_size == SZ_WORD) begin
            state_d     = WRITE;
            mem_wr_d    = 1'b1;
            mem_wdata_d = req_data;
          end else begin
            state_d  = READ;
            mem_rd_d = 1'b1;
          end
        end
      end
      READ: begin
        mem_rd_d = 1'b1;
        if (mem_ready) begin
          state_d     = WRITE;
          mem_rd_d    = 1'b0;
          mem_wr_d    = 1'b1;
          mem_wdata_d = merge_word(mem_rdata, data_q, size_q, lane_q);
        end
      end
      WRITE: begin
        mem_wr_d = 1'b1;
        if (mem_ready) begin
          state_d  = DONE;
          mem_wr_d = 1'b0;
          done_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      size_q      <= SZ_BYTE;
      lane_q      <= '0;
      data_q      <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      data_q      <= data_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
`timescale 1ns/1ps
// Bench for store_narrow_unit: vector table driven through a scoreboard of
// expected memory/done events, plus a reset-during-write sequence.
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        done, err;

  store_narrow_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // kind: 0 read handshake, 1 write handshake, 2 done pulse
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    int          stamp;
  } ev_t;

  // kind: 0 read-modify-write, 1 direct word write, 2 rejected
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] rdata;
    int          rs;
    int          ws;
    int          kind;
    logic [31:0] wdata;
  } vec_t;

  ev_t  sbq[$];
  ev_t  mon_e;
  vec_t vt[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  bit   mon_en = 1'b0;
  bit   busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (mem_rd && mem_wr) fail_now("rd_wr_both_high");
      if (busy) check("ready_low_busy", 32'(req_ready), 32'd0);
      if ((mem_rd || mem_wr) && !mem_ready && sbq.size() > 0) begin
        check("stall_addr", mem_addr, sbq[0].addr);
        if (mem_wr) check("stall_wdata", mem_wdata, sbq[0].wdata);
      end
      if (mem_rd && mem_ready) begin
        if (sbq.size() == 0) fail_now("unexpected_read");
        else begin
          mon_e = sbq.pop_front();
          check("rd_kind", 32'(mon_e.kind), 32'd0);
          check("rd_cycle", 32'(cyc), 32'(mon_e.stamp));
          check("rd_addr", mem_addr, mon_e.addr);
        end
      end
      if (mem_wr && mem_ready) begin
        if (sbq.size() == 0) fail_now("unexpected_write");
        else begin
          mon_e = sbq.pop_front();
          check("wr_kind", 32'(mon_e.kind), 32'd1);
          check("wr_cycle", 32'(cyc), 32'(mon_e.stamp));
          check("wr_addr", mem_addr, mon_e.addr);
          check("wr_data", mem_wdata, mon_e.wdata);
        end
      end
      if (err && !done) fail_now("err_without_done");
      if (done) begin
        done_cnt++;
        if (sbq.size() == 0) fail_now("unexpected_done");
        else begin
          mon_e = sbq.pop_front();
          check("done_kind", 32'(mon_e.kind), 32'd2);
          check("done_cycle", 32'(cyc), 32'(mon_e.stamp));
          check("done_err", 32'(err), 32'(mon_e.err));
        end
      end
    end
  end

  function automatic ev_t mk(int kind, logic [31:0] addr, logic [31:0] wdata, logic e, int stamp);
    ev_t x;
    x.kind = kind; x.addr = addr; x.wdata = wdata; x.err = e; x.stamp = stamp;
    return x;
  endfunction

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("ready_timeout");
  endtask

  task automatic run(input vec_t v);
    int c0, rw, ww, start;
    bit ok;
    logic [31:0] wa;
    wait_ready();
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_data  = v.data;
    req_size  = v.size;
    mem_rdata = v.rdata;
    mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data  = ~v.data;
    req_addr  = $urandom;
    req_size  = 2'($urandom_range(0, 3));
    c0 = cyc;
    busy = 1'b1;
    start = done_cnt;
    wa = {v.addr[31:2], 2'b00};
    case (v.kind)
      0: begin
        sbq.push_back(mk(0, wa, 32'h0, 1'b0, c0 + v.rs));
        sbq.push_back(mk(1, wa, v.wdata, 1'b0, c0 + 1 + v.rs + v.ws));
        sbq.push_back(mk(2, wa, 32'h0, 1'b0, c0 + 2 + v.rs + v.ws));
      end
      1: begin
        sbq.push_back(mk(1, wa, v.wdata, 1'b0, c0 + v.ws));
        sbq.push_back(mk(2, wa, 32'h0, 1'b0, c0 + 1 + v.ws));
      end
      default: sbq.push_back(mk(2, wa, 32'h0, 1'b1, c0));
    endcase
    rw = v.rs;
    ww = v.ws;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done_cnt != start) begin ok = 1'b1; break; end
      if (mem_rd) begin
        if (rw > 0) begin mem_ready = 1'b0; rw--; end else mem_ready = 1'b1;
      end else if (mem_wr) begin
        if (ww > 0) begin mem_ready = 1'b0; ww--; end else mem_ready = 1'b1;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    busy = 1'b0;
    if (!ok) fail_now("done_timeout");
    check("sb_drained", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    vec_t v;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);
    mon_en = 1'b1;

    //              addr          data          sz     rdata        rs ws kind wdata
    vt.push_back('{32'h0000_1002, 32'hAABBCC5A, 2'b00, 32'h11223344, 0, 0, 0, 32'h115A3344});
    vt.push_back('{32'h0000_2002, 32'h0000BEEF, 2'b01, 32'h11223344, 0, 0, 0, 32'hBEEF3344});
    vt.push_back('{32'h0000_2000, 32'h0000BEEF, 2'b01, 32'h11223344, 0, 0, 0, 32'h1122BEEF});
    vt.push_back('{32'h0000_3000, 32'hDEADBEEF, 2'b10, 32'h55555555, 0, 0, 1, 32'hDEADBEEF});
    vt.push_back('{32'h0000_4001, 32'h00001234, 2'b01, 32'h0,        0, 0, 2, 32'h0});
    vt.push_back('{32'h0000_4002, 32'h12345678, 2'b10, 32'h0,        0, 0, 2, 32'h0});
    vt.push_back('{32'h0000_4000, 32'h12345678, 2'b11, 32'h0,        0, 0, 2, 32'h0});
    vt.push_back('{32'h0000_4001, 32'h12345678, 2'b10, 32'h0,        0, 0, 2, 32'h0});
    vt.push_back('{32'h0000_4003, 32'h00005678, 2'b01, 32'h0,        0, 0, 2, 32'h0});
    vt.push_back('{32'h0000_5003, 32'h000000A5, 2'b00, 32'h01234567, 0, 0, 0, 32'hA5234567});
    vt.push_back('{32'h0000_5000, 32'h00000077, 2'b00, 32'hFFFFFFFF, 0, 0, 0, 32'hFFFFFF77});
    vt.push_back('{32'h0000_5001, 32'hFFFFFF12, 2'b00, 32'h00000000, 0, 0, 0, 32'h00001200});
    vt.push_back('{32'h0000_6001, 32'h1234569C, 2'b00, 32'hCAFEF00D, 3, 2, 0, 32'hCAFE9C0D});
    vt.push_back('{32'h0000_6002, 32'hFFFF1234, 2'b01, 32'hAAAAAAAA, 1, 0, 0, 32'h1234AAAA});
    vt.push_back('{32'h0000_7004, 32'h01020304, 2'b10, 32'h0,        0, 2, 1, 32'h01020304});

    foreach (vt[i]) run(vt[i]);

    // Reset while a merged write is stalled: write must be dropped, no done.
    mon_en = 1'b0;
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 32'h0000_8001;
    req_data  = 32'h00000033;
    req_size  = 2'b00;
    mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (mem_wr) begin ok = 1'b1; break; end
    end
    check("rstseq_wr_reached", 32'(ok), 32'd1);
    mem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstseq_ready_low", 32'(req_ready), 32'd0);
    check("rstseq_wr_before_edge", 32'(mem_wr), 32'd1);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("rstseq_wr_dropped", 32'(mem_wr), 32'd0);
    check("rstseq_rd_low", 32'(mem_rd), 32'd0);
    check("rstseq_no_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstseq_ready_after", 32'(req_ready), 32'd1);
      check("rstseq_idle_done", 32'(done), 32'd0);
      check("rstseq_idle_wr", 32'(mem_wr), 32'd0);
    end
    mon_en = 1'b1;
    v = '{32'h0000_8002, 32'h00000044, 2'b00, 32'h00000000, 0, 0, 0, 32'h00440000};
    run(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_narrow_unit.md
# store_narrow_unit

Store-side data path between the MEM stage and the data cache. It is the counterpart of the load-side sign extension. It takes a 32-bit register value plus a size and byte address, narrows it to byte, halfword or word, and performs the store. Sub-word stores use a read-modify-write sequence against the cache word port; word stores write directly. Misaligned or illegal-size requests are rejected without touching memory.

## Interface
Parameters:
- ADDR_W, 32, byte-address width; the word address is {addr[ADDR_W-1:2], 2'b00}

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request; combinational, equal to (state==IDLE) && !rst
- req_addr  in  ADDR_W  byte address
- req_data  in  32  register data; low bits are used for sub-word stores
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- mem_rd  out  1  word read request, registered
- mem_wr  out  1  word write request, registered
- mem_addr  out  ADDR_W  word-aligned address, registered
- mem_wdata  out  32  merged write word, registered
- mem_rdata  in  32  read data, valid when mem_ready is high during READ
- mem_ready  in  1  cache acknowledges the current mem_rd or mem_wr
- done  out  1  one-cycle pulse when a request completes
- err  out  1  one-cycle pulse coincident with done for a rejected request

## Operation
- States: IDLE, READ, WRITE, DONE, ERR.
- A request is accepted when req_valid && req_ready.
  - req_addr, req_data and req_size are captured at accept.
  - The inputs may change afterwards without effect.
- IDLE on accept:
  - size 11, half with addr[0]=1, or word with addr[1:0]!=0 → ERR.
  - word → WRITE, with mem_wdata = req_data.
  - byte or half → READ.
- READ:
  - mem_rd=1 and mem_addr = word address, both held until mem_ready.
  - On mem_ready, mem_rdata is merged and the state goes to WRITE.
- Merge rules (little-endian):
  - byte: lane k = addr[1:0]; bits [8k+7:8k] are replaced by req_data[7:0]; all other bits come from mem_rdata.
  - half, addr[1]=0: bits [15:0] are replaced by req_data[15:0].
  - half, addr[1]=1: bits [31:16] are replaced by req_data[15:0].
- WRITE:
  - mem_wr=1, with mem_addr and mem_wdata held until mem_ready.
  - On mem_ready → DONE.
- DONE: done=1 for one cycle → IDLE.
- ERR: done=1 and err=1 for one cycle → IDLE. No mem_rd or mem_wr is ever asserted for a rejected request.
- mem_rd and mem_wr are never high in the same cycle.
- mem_ready is ignored in IDLE, DONE and ERR.
- Reset:
  - state=IDLE.
  - mem_rd, mem_wr, done and err are 0.
  - mem_addr and mem_wdata are 0.
  - req_ready=0 while rst is high and 1 in the first cycle after rst falls.
- Reset mid-operation aborts the request. mem_rd and mem_wr are low from the cycle after the reset edge. No partial write is issued and no done pulse is generated.

## Timing
- All outputs except req_ready are registered.
- With mem_ready tied high and accept at edge 0:
  - byte or half: mem_rd high in cycle 1, mem_wr in cycle 2, done in cycle 3; next accept at cycle 4.
  - word: mem_wr in cycle 1, done in cycle 2.
  - rejected: done and err in cycle 1.
- Each cycle mem_ready is held low stretches READ or WRITE by one cycle, with outputs stable.
- req_ready is low from the cycle after accept through the DONE or ERR cycle inclusive.
- Throughput is one request in flight at a time; there is no queueing.

## Test plan
- Byte store: addr 0x1002, data 0xAABBCC5A, mem_rdata 0x11223344, mem_ready=1 → read of 0x1000, then write 0x115A3344; done in cycle 3.
- Half store: addr 0x2002, data 0x0000BEEF, mem_rdata 0x11223344 → write 0xBEEF3344. The same store at 0x2000 → 0x1122BEEF.
- Word store: addr 0x3000, data 0xDEADBEEF → no mem_rd; write 0xDEADBEEF in cycle 1; done in cycle 2.
- Rejections: half at 0x4001, word at 0x4002, and size 11 → err and done in cycle 1 each; mem_rd and mem_wr stay 0 throughout.
- Stall: mem_ready held low 3 cycles during READ and 2 cycles during WRITE → mem_addr and mem_wdata are stable; done arrives 5 cycles later than the no-stall case; req_data changed after accept has no effect.
- Reset during WRITE: assert rst with mem_wr=1 → mem_wr=0 the next cycle and no done; after rst falls, a new byte store completes correctly.
